// File: rtl/stage_mem.sv
// -----------------------------------------------------------------------------
// stage_mem -- memory stage of the in-order pipeline.
//
// Holds one instruction from execute in a stage register and performs its
// data-memory access, if it has one, through a simple req/ack port. While the
// access is outstanding the upstream pipeline is frozen with mem_stall.
// Misaligned accesses are never sent to memory; they are flagged for one cycle
// on mem_misalign and have their writeback suppressed.
//
// Handshake (dmem_*): dmem_req is held high, with dmem_we/addr/wdata stable,
// from the first ACCESS cycle until the cycle in which dmem_ack = 1. That
// cycle completes the request (dmem_rdata is sampled there). dmem_ack in any
// other cycle is ignored.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   ex_inst .. ex_rfSrc        instruction and control from execute
//   dmem_req/we/addr/wdata     request to data memory
//   dmem_rdata, dmem_ack       response from data memory
//   mem_inst, mem_rfWE,
//   mem_rfDst, mem_rfData      instruction and writeback to the register file
//   mem_stall                  freeze IF/ID/EX registers
//   mem_misalign               one-cycle flag for a misaligned access
//   dbg_state                  current FSM state (IDLE=0, ACCESS=1, DONE=2)
// -----------------------------------------------------------------------------
module stage_mem #(
    parameter int                     RF_SRC_W = 2,
    parameter logic [RF_SRC_W-1:0]    LOAD_SRC = RF_SRC_W'(2'b01)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         ex_inst,
    input  logic [31:0]         ex_opResult,
    input  logic                ex_memWE,
    input  logic [31:0]         ex_memData,
    input  logic                ex_rfWE,
    input  logic [4:0]          ex_rfDst,
    input  logic [RF_SRC_W-1:0] ex_rfSrc,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [31:0]         dmem_addr,
    output logic [31:0]         dmem_wdata,
    input  logic [31:0]         dmem_rdata,
    input  logic                dmem_ack,
    output logic [31:0]         mem_inst,
    output logic                mem_rfWE,
    output logic [4:0]          mem_rfDst,
    output logic [31:0]         mem_rfData,
    output logic                mem_stall,
    output logic                mem_misalign,
    output logic [1:0]          dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                state;

    // Stage register
    logic [31:0]           r_inst;
    logic [31:0]           r_opResult;
    logic                  r_memWE;
    logic [31:0]           r_memData;
    logic                  r_rfWE;
    logic [4:0]            r_rfDst;
    logic [RF_SRC_W-1:0]   r_rfSrc;

    logic [31:0]           load_data;

    // The ACCESS decision is made at the latch edge, so it is computed from
    // the instruction being latched (ex_*), not from the stage register.
    logic ex_needs_access;
    logic ex_aligned;
    assign ex_needs_access = ex_memWE || (ex_rfWE && (ex_rfSrc == LOAD_SRC));
    assign ex_aligned      = (ex_opResult[1:0] == 2'b00);

    logic r_needs_access;
    logic r_misaligned;
    logic in_access;
    assign r_needs_access = r_memWE || (r_rfWE && (r_rfSrc == LOAD_SRC));
    assign r_misaligned   = r_needs_access && (r_opResult[1:0] != 2'b00);
    assign in_access      = (state == ACCESS);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            r_inst     <= '0;
            r_opResult <= '0;
            r_memWE    <= 1'b0;
            r_memData  <= '0;
            r_rfWE     <= 1'b0;
            r_rfDst    <= '0;
            r_rfSrc    <= '0;
            load_data  <= '0;
        end else begin
            case (state)
                ACCESS: begin
                    // Stage register holds; only the ack can move us on.
                    if (dmem_ack) begin
                        load_data <= dmem_rdata;
                        state     <= DONE;
                    end
                end
                default: begin
                    // IDLE and DONE are both latch cycles (no stall).
                    r_inst     <= ex_inst;
                    r_opResult <= ex_opResult;
                    r_memWE    <= ex_memWE;
                    r_memData  <= ex_memData;
                    r_rfWE     <= ex_rfWE;
                    r_rfDst    <= ex_rfDst;
                    r_rfSrc    <= ex_rfSrc;
                    state      <= (ex_needs_access && ex_aligned) ? ACCESS : IDLE;
                end
            endcase
        end
    end

    // Request outputs are zeroed outside ACCESS so the bus is quiet when idle.
    assign dmem_req   = in_access;
    assign dmem_we    = in_access && r_memWE;
    assign dmem_addr  = in_access ? r_opResult : 32'h0;
    assign dmem_wdata = in_access ? r_memData  : 32'h0;

    assign mem_stall    = in_access;
    assign mem_misalign = r_misaligned;
    assign mem_inst     = r_inst;
    assign mem_rfDst    = r_rfDst;

    // A load writes back only in DONE (never while its access is pending),
    // so every instruction produces at most one writeback pulse.
    assign mem_rfWE   = r_rfWE && !in_access && !r_misaligned;
    assign mem_rfData = (r_rfSrc == LOAD_SRC) ? load_data : r_opResult;

    assign dbg_state = state;

endmodule
